unified_mem_sequencer: RTL and testbench
========================================

Name: unified_mem_sequencer

Overview:
- Owns the single port of the unified instruction/data memory and shares it between two requesters: the instruction-fetch side (PC/IR path) and the load/store side.
- Replaces free-running fetch/execute toggling with explicit request/ack handshakes, fixed data priority, and a fetch starvation guard.
- Sits between the core's fetch and data-access logic and the word-addressed memory array.

Parameters:
- RD_LAT, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..4.
- STREAK, 4, maximum consecutive data grants while if_req is pending before fetch is forced; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- if_req  input  1  fetch request, level, held until if_ack.
- if_addr  input  32  fetch byte address.
- if_ack  output  1  one-cycle fetch completion pulse.
- if_rdata  output  32  fetched word, valid only while if_ack=1.
- if_err  output  1  misaligned fetch, valid only while if_ack=1.
- d_req  input  1  data request, level, held until d_ack.
- d_we  input  1  1=store, 0=load.
- d_addr  input  32  data byte address.
- d_wdata  input  32  store data.
- d_ack  output  1  one-cycle data completion pulse.
- d_rdata  output  32  load word, valid only while d_ack=1.
- d_err  output  1  misaligned data access, valid only while d_ack=1.
- mem_en  output  1  memory access strobe, one cycle per access.
- mem_we  output  1  memory write enable, qualified by mem_en.
- mem_addr  output  30  word address, equal to the captured byte address [31:2].
- mem_wdata  output  32  write data.
- mem_rdata  input  32  read data, valid RD_LAT cycles after the mem_en cycle.
- busy  output  1  1 whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0 immediately; state=IDLE; streak=0; wait counter=0.
  - An in-flight transaction is discarded: no ack is issued and mem_en drops at once.
- Registers and outputs: all outputs are registered. Request inputs are sampled only in IDLE. The winner's address, d_we and d_wdata are captured at the grant edge; later input changes are ignored.
- States: IDLE, ACCESS, WAIT, RESP.
  - IDLE: if any req is high, the arbiter picks a winner and captures its inputs.
    - Aligned request (addr[1:0]=0): go to ACCESS.
    - Misaligned request: go to RESP with err=1, rdata=0, no memory access.
    - No request: stay in IDLE.
  - ACCESS: exactly one cycle with mem_en=1, mem_addr/mem_we/mem_wdata from the captured values.
    - Write: go to RESP.
    - Read: go to WAIT with counter=RD_LAT-1.
  - WAIT: decrement the counter each cycle. In the cycle mem_rdata is valid (RD_LAT cycles after ACCESS), capture it into the winner's rdata register and go to RESP.
  - RESP: the winner's ack=1 for exactly one cycle, then return to IDLE.
- Latency, with the grant at edge T (request seen in IDLE during cycle T-1 → state ACCESS from T):
  - Store: ack in cycle T+1.
  - Load: ack in cycle T+RD_LAT+1.
  - Misaligned: ack in cycle T.
  - Minimum spacing between grants is one IDLE cycle.
- Handshake rules:
  - A requester deasserts req at the same edge where it samples ack=1.
  - A req still high in the following IDLE cycle is a new request.
  - Ack is never asserted for the non-winner.
  - if_rdata/d_rdata hold their value after ack but are only defined during ack.
- Arbitration:
  - When both requests are high, data wins, unless streak==STREAK, in which case fetch wins.
  - streak increments (saturating at STREAK) on a data grant made while if_req=1.
  - streak clears on a fetch grant, or on a data grant made while if_req=0.
  - When only one request is high, it wins and the streak rules above still apply.
- Stores: d_rdata=0 at ack, d_err=0.
- Simultaneous events: a request arriving while busy=1 waits; there is no queuing beyond the level-held req.
- Misaligned accesses consume no memory cycle and count as grants for streak purposes.

Test Plan:
- Reset, then a single fetch: RD_LAT=1, if_addr=0x10, mem_rdata=0xDEADBEEF → mem_en once with mem_addr=0x4, mem_we=0; if_ack 3 cycles after if_req is seen, if_rdata=0xDEADBEEF.
- Store then load: d_we=1, d_addr=0x20, d_wdata=0x12345678 → mem_we=1, mem_addr=0x8, d_ack 2 cycles after the request is seen. Follow with a load of 0x20, memory model returning the stored word → d_rdata=0x12345678.
- Starvation guard: STREAK=4, if_req and d_req both held continuously → grant order D,D,D,D,F,D,D,D,D,F; no fetch wait exceeds 4 data transactions.
- Misaligned access: d_addr=0x22 → d_ack one cycle after grant with d_err=1, d_rdata=0, mem_en never asserted.
- Latency sweep: RD_LAT=3 → load ack exactly 5 cycles after the request is seen (grant edge → ACCESS, 3 wait cycles, then RESP); busy=1 for 5 cycles.
- Mid-operation reset: assert rst=0 while in WAIT → mem_en, busy and the acks are 0 immediately, no ack is issued after release, and the first request after release completes normally.

Source files
------------

// File: rtl/unified_mem_sequencer.sv
// unified_mem_sequencer
//   Shares the single port of the unified instruction/data memory between the
//   fetch requester (if_*) and the load/store requester (d_*). Each access is a
//   req/ack handshake. Data wins ties unless fetch has been passed over STREAK
//   times in a row while waiting, in which case fetch is forced through.
//
// Parameters
//   RD_LAT  cycles from the mem_en cycle to valid mem_rdata (1..4)
//   STREAK  max consecutive data grants while if_req is pending (1..15)
//
// Ports
//   clk, rst                    clock (rising edge), asynchronous active-low reset
//   if_req/if_addr              fetch request (level) and byte address
//   if_ack/if_rdata/if_err      fetch completion pulse, word, misalignment flag
//   d_req/d_we/d_addr/d_wdata   data request (level), store flag, address, store data
//   d_ack/d_rdata/d_err         data completion pulse, load word, misalignment flag
//   mem_en/mem_we               one-cycle access strobe, write enable
//   mem_addr/mem_wdata          word address (byte address [31:2]), write data
//   mem_rdata                   read data, valid RD_LAT cycles after mem_en
//   busy                        high whenever the sequencer is not idle
module unified_mem_sequencer #(
  parameter int RD_LAT = 1,
  parameter int STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [1:0] CNT_INIT   = 2'(RD_LAT - 1);
  localparam logic [3:0] STREAK_MAX = 4'(STREAK);

  state_t      state_reg, state_next;
  logic [3:0]  streak_reg, streak_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic        win_d_reg, win_d_next;   // 1: data side owns the transaction
  logic        we_reg, we_next;
  logic        mem_en_reg, mem_en_next;
  logic        mem_we_reg, mem_we_next;
  logic [29:0] mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;
  logic        busy_reg, busy_next;

  // Response handed to one requester's output registers (bit 0 fetch, bit 1 data)
  logic [1:0]  resp_fire;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // Arbitration, only meaningful while IDLE
  logic        any_req;
  logic        force_fetch;
  logic        grant_d;
  logic [31:0] sel_addr;
  logic        misaligned;

  assign any_req     = if_req || d_req;
  assign force_fetch = if_req && (streak_reg == STREAK_MAX);
  assign grant_d     = d_req && !force_fetch;
  assign sel_addr    = grant_d ? d_addr : if_addr;
  assign misaligned  = (sel_addr[1:0] != 2'b00);

  // State and internal/memory-side registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      streak_reg    <= '0;
      cnt_reg       <= '0;
      win_d_reg     <= 1'b0;
      we_reg        <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      streak_reg    <= streak_next;
      cnt_reg       <= cnt_next;
      win_d_reg     <= win_d_next;
      we_reg        <= we_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      busy_reg      <= busy_next;
    end
  end

  // Next-state, streak and read-latency counter
  always_comb begin
    state_next  = state_reg;
    streak_next = streak_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = misaligned ? RESP : ACCESS;
          // Only a data grant that passes over a waiting fetch extends the streak
          if (grant_d && if_req)
            streak_next = (streak_reg == STREAK_MAX) ? streak_reg : streak_reg + 4'd1;
          else
            streak_next = '0;
        end
      end
      ACCESS: begin
        if (we_reg) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
          cnt_next   = CNT_INIT;
        end
      end
      WAIT: begin
        // cnt_reg reaches zero in the cycle mem_rdata is valid
        if (cnt_reg == 2'd0) state_next = RESP;
        else                 cnt_next   = cnt_reg - 2'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output and capture logic (next values for the registered outputs)
  always_comb begin
    win_d_next     = win_d_reg;
    we_next        = we_reg;
    mem_en_next    = 1'b0;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    busy_next      = (state_next != IDLE);
    resp_fire      = 2'b00;
    resp_rdata     = '0;
    resp_err       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          win_d_next     = grant_d;
          we_next        = grant_d && d_we;
          mem_addr_next  = sel_addr[31:2];
          mem_wdata_next = grant_d ? d_wdata : '0;
          if (misaligned) begin
            // No memory cycle: answer straight away with the error flag
            resp_fire = grant_d ? 2'b10 : 2'b01;
            resp_err  = 1'b1;
          end else begin
            mem_en_next = 1'b1;
            mem_we_next = grant_d && d_we;
          end
        end
      end
      ACCESS: begin
        if (we_reg) resp_fire = win_d_reg ? 2'b10 : 2'b01;
      end
      WAIT: begin
        if (cnt_reg == 2'd0) begin
          resp_fire  = win_d_reg ? 2'b10 : 2'b01;
          resp_rdata = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  // Per-requester response registers; rdata/err hold between acks
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic        ack_reg;
      logic        err_reg;
      logic [31:0] rdata_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= '0;
        end else begin
          ack_reg <= resp_fire[gi];
          if (resp_fire[gi]) begin
            rdata_reg <= resp_rdata;
            err_reg   <= resp_err;
          end
        end
      end
    end
  endgenerate

  assign if_ack    = g_port[0].ack_reg;
  assign if_rdata  = g_port[0].rdata_reg;
  assign if_err    = g_port[0].err_reg;
  assign d_ack     = g_port[1].ack_reg;
  assign d_rdata   = g_port[1].rdata_reg;
  assign d_err     = g_port[1].err_reg;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_unified_mem_sequencer.sv
module tb_unified_mem_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // unit 1: RD_LAT=1, unit 3: RD_LAT=3
  logic        if_req1, if_ack1, if_err1, d_req1, d_we1, d_ack1, d_err1;
  logic [31:0] if_addr1, if_rdata1, d_addr1, d_wdata1, d_rdata1;
  logic        mem_en1, mem_we1, busy1;
  logic [29:0] mem_addr1;
  logic [31:0] mem_wdata1, mem_rdata1;

  logic        if_req3, if_ack3, if_err3, d_req3, d_we3, d_ack3, d_err3;
  logic [31:0] if_addr3, if_rdata3, d_addr3, d_wdata3, d_rdata3;
  logic        mem_en3, mem_we3, busy3;
  logic [29:0] mem_addr3;
  logic [31:0] mem_wdata3, mem_rdata3;

  unified_mem_sequencer #(.RD_LAT(1), .STREAK(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_ack(if_ack1), .if_rdata(if_rdata1), .if_err(if_err1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_ack(d_ack1), .d_rdata(d_rdata1), .d_err(d_err1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  unified_mem_sequencer #(.RD_LAT(3), .STREAK(4)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3), .if_err(if_err3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_ack(d_ack3), .d_rdata(d_rdata3), .d_err(d_err3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Memory models: unwritten words read a fixed pattern; data is only valid
  // in the exact cycle RD_LAT after mem_en, otherwise a filler word.
  function automatic logic [31:0] preset(input logic [5:0] idx);
    return (idx == 6'd4) ? 32'hDEADBEEF : (32'h5A000000 | {26'd0, idx});
  endfunction

  bit [31:0] mem1 [64];
  bit        wr1  [64];
  bit [2:0]  v1;
  bit [5:0]  a1_0;
  always @(posedge clk) begin
    if (mem_en1 && mem_we1) begin
      mem1[mem_addr1[5:0]] <= mem_wdata1;
      wr1[mem_addr1[5:0]]  <= 1'b1;
    end
    v1   <= {v1[1:0], mem_en1 && !mem_we1};
    a1_0 <= mem_addr1[5:0];
  end
  assign mem_rdata1 = v1[0] ? (wr1[a1_0] ? mem1[a1_0] : preset(a1_0)) : 32'hA5A5A5A5;

  bit [31:0] mem3 [64];
  bit        wr3  [64];
  bit [2:0]  v3;
  bit [5:0]  a3_0, a3_1, a3_2;
  always @(posedge clk) begin
    if (mem_en3 && mem_we3) begin
      mem3[mem_addr3[5:0]] <= mem_wdata3;
      wr3[mem_addr3[5:0]]  <= 1'b1;
    end
    v3   <= {v3[1:0], mem_en3 && !mem_we3};
    a3_0 <= mem_addr3[5:0];
    a3_1 <= a3_0;
    a3_2 <= a3_1;
  end
  assign mem_rdata3 = v3[2] ? (wr3[a3_2] ? mem3[a3_2] : preset(a3_2)) : 32'hA5A5A5A5;

  // Activity monitors
  int          en_cnt1 = 0, en_cnt3 = 0, busy_cnt1 = 0, busy_cnt3 = 0;
  logic [29:0] last_addr1, last_addr3;
  logic        last_we1, last_we3;
  logic [31:0] last_wd1, last_wd3;
  always @(negedge clk) begin
    if (mem_en1) begin
      en_cnt1    <= en_cnt1 + 1;
      last_addr1 <= mem_addr1;
      last_we1   <= mem_we1;
      last_wd1   <= mem_wdata1;
    end
    if (mem_en3) begin
      en_cnt3    <= en_cnt3 + 1;
      last_addr3 <= mem_addr3;
      last_we3   <= mem_we3;
      last_wd3   <= mem_wdata3;
    end
    if (busy1) busy_cnt1 <= busy_cnt1 + 1;
    if (busy3) busy_cnt3 <= busy_cnt3 + 1;
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic ack_of(input int u, input bit is_d);
    if (u == 1) return is_d ? d_ack1 : if_ack1;
    return is_d ? d_ack3 : if_ack3;
  endfunction

  function automatic logic [31:0] rdata_of(input int u, input bit is_d);
    if (u == 1) return is_d ? d_rdata1 : if_rdata1;
    return is_d ? d_rdata3 : if_rdata3;
  endfunction

  function automatic logic err_of(input int u, input bit is_d);
    if (u == 1) return is_d ? d_err1 : if_err1;
    return is_d ? d_err3 : if_err3;
  endfunction

  task automatic set_req(input int u, input bit is_d, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (u == 1) begin
      if (is_d) begin d_req1 = 1'b1; d_we1 = we; d_addr1 = addr; d_wdata1 = wdata; end
      else begin if_req1 = 1'b1; if_addr1 = addr; end
    end else begin
      if (is_d) begin d_req3 = 1'b1; d_we3 = we; d_addr3 = addr; d_wdata3 = wdata; end
      else begin if_req3 = 1'b1; if_addr3 = addr; end
    end
  endtask

  task automatic clr_req(input int u);
    if (u == 1) begin if_req1 = 1'b0; d_req1 = 1'b0; end
    else begin if_req3 = 1'b0; d_req3 = 1'b0; end
  endtask

  // One request/ack transaction; starts and ends shortly after a falling edge
  // with the sequencer idle. exp_lat counts rising edges from request to ack.
  task automatic txn(input int u, input bit is_d, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int exp_lat, input logic [31:0] exp_rdata,
                     input bit exp_err, input int exp_en);
    int          lat, en0, b0, en_d, b_d;
    bit          got;
    logic [31:0] rd;
    logic        er, oth;
    logic [29:0] la;
    logic        lw;
    logic [31:0] lwd;
    string       kind;
    kind = is_d ? (we ? "store" : "load") : "fetch";
    en0 = (u == 1) ? en_cnt1 : en_cnt3;
    b0  = (u == 1) ? busy_cnt1 : busy_cnt3;
    set_req(u, is_d, we, addr, wdata);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (ack_of(u, is_d)) got = 1'b1;
      else if (lat == 1) set_req(u, is_d, ~we, addr ^ 32'h00000F00, ~wdata); // must be ignored
    end
    rd  = rdata_of(u, is_d);
    er  = err_of(u, is_d);
    oth = ack_of(u, !is_d);
    clr_req(u);
    if (!got) begin
      chk({kind, "_timeout"}, 32'(got), 32'd1);
    end else begin
      chk({kind, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({kind, "_rdata"}, rd, exp_rdata);
      chk({kind, "_err"}, 32'(er), 32'(exp_err));
      chk({kind, "_other_ack"}, 32'(oth), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    en_d = ((u == 1) ? en_cnt1 : en_cnt3) - en0;
    b_d  = ((u == 1) ? busy_cnt1 : busy_cnt3) - b0;
    la   = (u == 1) ? last_addr1 : last_addr3;
    lw   = (u == 1) ? last_we1 : last_we3;
    lwd  = (u == 1) ? last_wd1 : last_wd3;
    chk({kind, "_mem_en_count"}, 32'(en_d), 32'(exp_en));
    chk({kind, "_busy_cycles"}, 32'(b_d), 32'(exp_lat));
    if (exp_en > 0) begin
      chk({kind, "_mem_addr"}, {2'b00, la}, {2'b00, addr[31:2]});
      chk({kind, "_mem_we"}, 32'(lw), 32'(we));
      if (we) chk({kind, "_mem_wdata"}, lwd, wdata);
    end
    $display("txn unit=%0d %s addr=%h lat=%0d rdata=%h err=%0d", u, kind, addr, lat, rd, er);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] order;
    int         k, cyc, since_f, max_wait, acks;

    rst = 1'b0;
    if_req1 = 0; if_addr1 = 0; d_req1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0;
    if_req3 = 0; if_addr3 = 0; d_req3 = 0; d_we3 = 0; d_addr3 = 0; d_wdata3 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_mem_en1", 32'(mem_en1), 32'd0);
    chk("rst_if_ack1", 32'(if_ack1), 32'd0);
    chk("rst_d_ack1", 32'(d_ack1), 32'd0);
    chk("rst_mem_addr1", {2'b00, mem_addr1}, 32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    #1;

    // Single fetch, store, load-back, misaligned accesses (RD_LAT=1)
    txn(1, 0, 0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 0, 1);
    txn(1, 1, 1, 32'h20, 32'h12345678, 2, 32'h0, 0, 1);
    txn(1, 1, 0, 32'h20, 32'h0, 3, 32'h12345678, 0, 1);
    txn(1, 1, 0, 32'h22, 32'h0, 1, 32'h0, 1, 0);
    txn(1, 0, 0, 32'h13, 32'h0, 1, 32'h0, 1, 0);
    txn(1, 1, 1, 32'h26, 32'hFFFF0000, 1, 32'h0, 1, 0);
    txn(1, 1, 0, 32'h24, 32'h0, 3, 32'h5A000009, 0, 1);

    // Starvation guard: both requests held continuously
    order = '0; k = 0; cyc = 0; since_f = 0; max_wait = 0;
    set_req(1, 0, 0, 32'h10, 32'h0);
    set_req(1, 1, 1, 32'h40, 32'hCAFE0001);
    while (k < 10 && cyc < 200) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (if_ack1) begin
        order[k] = 1'b1;
        k++;
        since_f = 0;
      end else if (d_ack1) begin
        k++;
        since_f++;
        if (since_f > max_wait) max_wait = since_f;
      end
    end
    clr_req(1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("grant_count", 32'(k), 32'd10);
    chk("grant_order", 32'(order), 32'h210);
    chk("fetch_max_wait", 32'(max_wait), 32'd4);
    $display("txn unit=1 contention grants=%0d order=%b max_wait=%0d", k, order, max_wait);

    // Latency sweep (RD_LAT=3)
    txn(3, 1, 0, 32'h30, 32'h0, 5, 32'h5A00000C, 0, 1);
    txn(3, 0, 0, 32'h10, 32'h0, 5, 32'hDEADBEEF, 0, 1);
    txn(3, 1, 1, 32'h44, 32'h600DF00D, 2, 32'h0, 0, 1);
    txn(3, 1, 0, 32'h44, 32'h0, 5, 32'h600DF00D, 0, 1);

    // Reset while unit 3 waits on read data and unit 1 is in its access cycle
    set_req(3, 1, 0, 32'h30, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    set_req(1, 1, 0, 32'h20, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_busy3", 32'(busy3), 32'd1);
    chk("pre_rst_mem_en1", 32'(mem_en1), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy3", 32'(busy3), 32'd0);
    chk("mid_rst_busy1", 32'(busy1), 32'd0);
    chk("mid_rst_mem_en1", 32'(mem_en1), 32'd0);
    chk("mid_rst_acks", 32'({d_ack1, if_ack1, d_ack3, if_ack3}), 32'd0);
    clr_req(1);
    clr_req(3);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      acks += int'(d_ack1) + int'(if_ack1) + int'(d_ack3) + int'(if_ack3);
    end
    #1;
    chk("post_rst_no_ack", 32'(acks), 32'd0);
    $display("txn reset during access/wait, acks after release=%0d", acks);
    txn(3, 1, 0, 32'h30, 32'h0, 5, 32'h5A00000C, 0, 1);
    txn(1, 0, 0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 0, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
